// File: rtl/sipo_rx_if.sv
// Handshake bundle between a serial bit source / word consumer and sipo_rx.
// The parity_err signal exists only when SIPO_RX_PARITY_EN is defined.
interface sipo_rx_if #(
    parameter int unsigned WIDTH = 4
);
    logic             d;
    logic             en;
    logic             start;
    logic             ack;
    logic [WIDTH-1:0] q;
    logic             valid;
    logic             busy;
    logic             overrun;
`ifdef SIPO_RX_PARITY_EN
    logic             parity_err;

    modport master (output d, en, start, ack,
                    input  q, valid, busy, overrun, parity_err);
    modport slave  (input  d, en, start, ack,
                    output q, valid, busy, overrun, parity_err);
`else
    modport master (output d, en, start, ack,
                    input  q, valid, busy, overrun);
    modport slave  (input  d, en, start, ack,
                    output q, valid, busy, overrun);
`endif
endinterface

// File: rtl/sipo_rx.sv
// Serial-in/parallel-out word receiver with valid/ack output handshake.
// Define SIPO_RX_PARITY_EN to append an even-parity bit to every frame.
module sipo_rx #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input logic     clk,
    input logic     reset,
    sipo_rx_if.slave bus
);

`ifdef SIPO_RX_PARITY_EN
    localparam int unsigned LAST = WIDTH;
`else
    localparam int unsigned LAST = WIDTH - 1;
`endif
    localparam int unsigned CNT_W = $clog2(LAST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               ovr_q, ovr_d;
`ifdef SIPO_RX_PARITY_EN
    logic               par_q, par_d;
    logic               perr_q, perr_d;
`endif

    logic [WIDTH-1:0]   shifted;
    logic [WIDTH-1:0]   first;
    logic [WIDTH-1:0]   word;
    logic               done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            q_q     <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            q_q     <= q_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
`ifdef SIPO_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        q_d     = q_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        busy_d  = 1'b0;
        done    = 1'b0;
`ifdef SIPO_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = perr_q;
`endif

        if (MSB_FIRST) begin
            shifted = {sr_q[WIDTH-2:0], bus.d};
            first   = {{(WIDTH-1){1'b0}}, bus.d};
        end else begin
            shifted = {bus.d, sr_q[WIDTH-1:1]};
            first   = {bus.d, {(WIDTH-1){1'b0}}};
        end

        // With parity the final bit is the parity bit, so the word is already fully shifted in.
`ifdef SIPO_RX_PARITY_EN
        word = sr_q;
`else
        word = shifted;
`endif

        if (bus.en) begin
            if (bus.start) begin
                state_d = SHIFT;
                cnt_d   = CNT_W'(1);
                sr_d    = first;
`ifdef SIPO_RX_PARITY_EN
                par_d   = bus.d;
`endif
            end else if (state_q == SHIFT) begin
                if (cnt_q == CNT_W'(LAST)) begin
                    done    = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    sr_d    = shifted;
`ifdef SIPO_RX_PARITY_EN
                    par_d   = par_q ^ bus.d;
`endif
                end
            end
        end

        // A completed word loads only into a free (or simultaneously acked) output slot.
        if (done) begin
            if (!valid_q || bus.ack) begin
                q_d     = word;
                valid_d = 1'b1;
`ifdef SIPO_RX_PARITY_EN
                perr_d  = par_q ^ bus.d;
`endif
            end else begin
                ovr_d   = 1'b1;
            end
        end else if (bus.ack) begin
            valid_d = 1'b0;
        end

        busy_d = (state_d == SHIFT);
    end

    assign bus.q       = q_q;
    assign bus.valid   = valid_q;
    assign bus.busy    = busy_q;
    assign bus.overrun = ovr_q;
`ifdef SIPO_RX_PARITY_EN
    assign bus.parity_err = perr_q;
`endif

endmodule

// File: tb/tb_sipo_rx.sv
// Bench for sipo_rx: MSB-first and LSB-first instances share one stimulus stream.
// Frame vectors come from a table; completed words are checked through a scoreboard queue.
module tb_sipo_rx;
    localparam int unsigned W = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sipo_rx_if #(.WIDTH(W)) if_m ();
    sipo_rx_if #(.WIDTH(W)) if_l ();

    assign if_l.d     = if_m.d;
    assign if_l.en    = if_m.en;
    assign if_l.start = if_m.start;
    assign if_l.ack   = if_m.ack;

    sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .reset(reset), .bus(if_m));
    sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .reset(reset), .bus(if_l));

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [W-1:0] qm;
        logic [W-1:0] ql;
        logic         valid;
        logic         ovr;
        logic         perr;
    } exp_t;

    typedef struct {
        logic [W-1:0] seq;        // seq[W-1] is transmitted first
        int           gap;
        logic         ack_last;
        logic         ack_after;
        logic         rst_before;
        exp_t         e;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[6];

    function automatic exp_t mk_exp(input logic [W-1:0] qm, input logic [W-1:0] ql,
                                    input logic valid, input logic ovr, input logic perr);
        exp_t e;
        e.qm = qm; e.ql = ql; e.valid = valid; e.ovr = ovr; e.perr = perr;
        return e;
    endfunction

    function automatic vec_t mk_vec(input logic [W-1:0] seq, input int gap, input logic ack_last,
                                    input logic ack_after, input logic rst_before, input exp_t e);
        vec_t v;
        v.seq = seq; v.gap = gap; v.ack_last = ack_last;
        v.ack_after = ack_after; v.rst_before = rst_before; v.e = e;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e, input logic busy);
        chk({tag, " q_msb"},     32'(if_m.q),       32'(e.qm));
        chk({tag, " q_lsb"},     32'(if_l.q),       32'(e.ql));
        chk({tag, " valid_msb"}, 32'(if_m.valid),   32'(e.valid));
        chk({tag, " valid_lsb"}, 32'(if_l.valid),   32'(e.valid));
        chk({tag, " ovr_msb"},   32'(if_m.overrun), 32'(e.ovr));
        chk({tag, " ovr_lsb"},   32'(if_l.overrun), 32'(e.ovr));
        chk({tag, " busy_msb"},  32'(if_m.busy),    32'(busy));
        chk({tag, " busy_lsb"},  32'(if_l.busy),    32'(busy));
`ifdef SIPO_RX_PARITY_EN
        chk({tag, " perr_msb"},  32'(if_m.parity_err), 32'(e.perr));
        chk({tag, " perr_lsb"},  32'(if_l.parity_err), 32'(e.perr));
`endif
    endtask

    task automatic busy_is(input string tag, input logic b);
        chk({tag, " busy_msb"}, 32'(if_m.busy), 32'(b));
        chk({tag, " busy_lsb"}, 32'(if_l.busy), 32'(b));
    endtask

    task automatic valid_is(input string tag, input logic v);
        chk({tag, " valid_msb"}, 32'(if_m.valid), 32'(v));
        chk({tag, " valid_lsb"}, 32'(if_l.valid), 32'(v));
    endtask

    task automatic send_bit(input logic d, input logic start, input logic ack);
        if_m.d = d; if_m.en = 1'b1; if_m.start = start; if_m.ack = ack;
        tick();
        if_m.d = 1'b0; if_m.en = 1'b0; if_m.start = 1'b0; if_m.ack = 1'b0;
    endtask

    // Sends one frame; the parity bit (if any) is chosen to produce the expected parity_err.
    task automatic send_frame(input string tag, input logic [W-1:0] seq, input int gap,
                              input logic ack_last, input exp_t e);
        int nb;
`ifdef SIPO_RX_PARITY_EN
        nb = W + 1;
`else
        nb = W;
`endif
        for (int i = 0; i < nb; i++) begin
            logic b;
            logic last;
            last = (i == nb - 1);
            if (i < W) b = seq[W-1-i];
            else       b = (^seq) ^ e.perr;
            if (last) sb_q.push_back(e);
            send_bit(b, i == 0, ack_last && last);
            if (!last) begin
                busy_is({tag, " mid"}, 1'b1);
                for (int g = 0; g < gap; g++) begin
                    tick();
                    busy_is({tag, " gap"}, 1'b1);
                end
            end
        end
    endtask

    task automatic check_sb(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard: got empty queue expected a word", tag);
        end else begin
            e = sb_q.pop_front();
            chk_all({tag, " done"}, e, 1'b0);
        end
    endtask

    task automatic do_ack(input string tag, input exp_t e);
        exp_t a;
        a = e;
        a.valid = 1'b0;
        if_m.ack = 1'b1;
        tick();
        if_m.ack = 1'b0;
        chk_all({tag, " ack"}, a, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk_all({tag, " reset"}, mk_exp('0, '0, 1'b0, 1'b0, 1'b0), 1'b0);
    endtask

    initial begin
        exp_t e;
        reset = 1'b1;
        if_m.d = 1'b0; if_m.en = 1'b0; if_m.start = 1'b0; if_m.ack = 1'b0;

        vecs[0] = mk_vec(4'b1001, 0, 1'b0, 1'b1, 1'b0, mk_exp(4'b1001, 4'b1001, 1'b1, 1'b0, 1'b0));
        vecs[1] = mk_vec(4'b1101, 3, 1'b0, 1'b1, 1'b0, mk_exp(4'b1101, 4'b1011, 1'b1, 1'b0, 1'b0));
        vecs[2] = mk_vec(4'b1000, 0, 1'b0, 1'b0, 1'b0, mk_exp(4'b1000, 4'b0001, 1'b1, 1'b0, 1'b0));
        vecs[3] = mk_vec(4'b0001, 0, 1'b0, 1'b1, 1'b0, mk_exp(4'b1000, 4'b0001, 1'b1, 1'b1, 1'b0));
        vecs[4] = mk_vec(4'b1001, 0, 1'b0, 1'b0, 1'b1, mk_exp(4'b1001, 4'b1001, 1'b1, 1'b0, 1'b0));
        vecs[5] = mk_vec(4'b0110, 0, 1'b1, 1'b1, 1'b0, mk_exp(4'b0110, 4'b0110, 1'b1, 1'b0, 1'b0));

        do_reset("init");

        for (int k = 0; k < 6; k++) begin
            string tag;
            tag = $sformatf("vec%0d", k);
            if (vecs[k].rst_before) do_reset(tag);
            send_frame(tag, vecs[k].seq, vecs[k].gap, vecs[k].ack_last, vecs[k].e);
            check_sb(tag);
            if (vecs[k].ack_after) do_ack(tag, vecs[k].e);
        end

        // Restart mid-frame: the two-bit partial must never surface.
        send_bit(1'b1, 1'b1, 1'b0);
        busy_is("restart partial", 1'b1);
        send_bit(1'b1, 1'b0, 1'b0);
        valid_is("restart partial", 1'b0);
        e = mk_exp(4'b0001, 4'b1000, 1'b1, 1'b0, 1'b0);
        send_frame("restart", 4'b0001, 0, 1'b0, e);
        check_sb("restart");
        do_ack("restart", e);
        for (int i = 0; i < 3; i++) begin
            tick();
            valid_is("restart single", 1'b0);
        end

        // A bit without start in IDLE is ignored.
        send_bit(1'b1, 1'b0, 1'b0);
        busy_is("idle ignore", 1'b0);
        valid_is("idle ignore", 1'b0);

        // Reset after three bits aborts the frame and clears q.
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_all("midreset", mk_exp('0, '0, 1'b0, 1'b0, 1'b0), 1'b0);
        e = mk_exp(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0);
        send_frame("after_reset", 4'b1111, 0, 1'b0, e);
        check_sb("after_reset");
        do_ack("after_reset", e);

`ifdef SIPO_RX_PARITY_EN
        e = mk_exp(4'b1011, 4'b1101, 1'b1, 1'b0, 1'b0);
        send_frame("par_good", 4'b1011, 0, 1'b0, e);
        check_sb("par_good");
        do_ack("par_good", e);
        e = mk_exp(4'b1011, 4'b1101, 1'b1, 1'b0, 1'b1);
        send_frame("par_bad", 4'b1011, 0, 1'b0, e);
        check_sb("par_bad");
        do_ack("par_bad", e);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

endmodule
